// File: rtl/lock_cmd_issuer.sv
// Debounces set/enter buttons, issues SET/CHECK to the lock (release->cmd_valid = DEBOUNCE_CYCLES+3 clocks), holds cmd until cmd_ready.
// Tracks verdicts and failure count; timed LOCKOUT only when LOCK_LOCKOUT_EN is defined.
module lock_cmd_issuer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
  parameter logic [2:0]  MAX_FAILS       = 3'd3,
  parameter logic [15:0] LOCKOUT_CYCLES  = 16'd50000,
  parameter logic [7:0]  RESP_TIMEOUT    = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_set_raw,
  input  logic       btn_enter_raw,
  input  logic [6:0] code_sw,
  output logic       cmd_valid,
  output logic [1:0] cmd_op,
  output logic [6:0] cmd_code,
  input  logic       cmd_ready,
  input  logic       resp_valid,
  input  logic       resp_ok,
  output logic       busy,
  output logic       locked_out,
  output logic [2:0] fail_count,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_LOCK  = 2'd3
  } state_t;

  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CHECK = 2'b10;

  if (DEBOUNCE_CYCLES == 16'd0 || MAX_FAILS == 3'd0 ||
      LOCKOUT_CYCLES == 16'd0 || RESP_TIMEOUT == 8'd0) begin : g_param_check
    $error("lock_cmd_issuer: parameters must be nonzero");
  end

  logic [1:0] set_sync;
  logic [1:0] ent_sync;
  logic [6:0] code_s1;
  logic [6:0] code_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_sync <= '0;
      ent_sync <= '0;
      code_s1  <= '0;
      code_s2  <= '0;
    end else begin
      set_sync <= {set_sync[0], btn_set_raw};
      ent_sync <= {ent_sync[0], btn_enter_raw};
      code_s1  <= code_sw;
      code_s2  <= code_s1;
    end
  end

  logic [1:0] btn_lvl;
  logic [1:0] rel_evt;
  assign btn_lvl = {ent_sync[1], set_sync[1]};

  // Index 0 = set, 1 = enter; rel_evt pulses for one cycle when a debounced level falls.
  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic        deb_q;
    logic        evt_q;
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_q <= 1'b0;
        evt_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        evt_q <= 1'b0;
        if (btn_lvl[i] == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
          deb_q <= btn_lvl[i];
          evt_q <= deb_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end

    assign rel_evt[i] = evt_q;
  end

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [6:0] code_q, code_d;
  logic [2:0] fail_q, fail_d;
  logic [2:0] fail_inc;
  logic [7:0] rsp_tmr_q, rsp_tmr_d;
  logic       rsp_expired;

  assign fail_inc    = (fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1;
  assign rsp_expired = (rsp_tmr_q == RESP_TIMEOUT - 8'd1);

`ifdef LOCK_LOCKOUT_EN
  logic [15:0] lock_tmr_q, lock_tmr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_tmr_q <= '0;
    else        lock_tmr_q <= lock_tmr_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      code_q    <= '0;
      fail_q    <= '0;
      rsp_tmr_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      code_q    <= code_d;
      fail_q    <= fail_d;
      rsp_tmr_q <= rsp_tmr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    code_d    = code_q;
    fail_d    = fail_q;
    rsp_tmr_d = rsp_tmr_q;
`ifdef LOCK_LOCKOUT_EN
    lock_tmr_d = lock_tmr_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Enter takes priority over a simultaneous set release.
        if (rel_evt[1]) begin
          op_d    = OP_CHECK;
          code_d  = code_s2;
          state_d = S_ISSUE;
        end else if (rel_evt[0]) begin
          op_d    = OP_SET;
          code_d  = code_s2;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          state_d   = (op_q == OP_CHECK) ? S_WAIT : S_IDLE;
          rsp_tmr_d = '0;
          op_d      = '0;
          code_d    = '0;
        end
      end
      S_WAIT: begin
        if (resp_valid && resp_ok) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end else if (resp_valid || rsp_expired) begin
          fail_d  = fail_inc;
          state_d = S_IDLE;
`ifdef LOCK_LOCKOUT_EN
          if (fail_inc == MAX_FAILS) begin
            state_d    = S_LOCK;
            lock_tmr_d = LOCKOUT_CYCLES;
          end
`endif
        end else if (rsp_tmr_q != RESP_TIMEOUT) begin
          rsp_tmr_d = rsp_tmr_q + 8'd1;
        end
      end
`ifdef LOCK_LOCKOUT_EN
      S_LOCK: begin
        if (lock_tmr_q <= 16'd1) begin
          lock_tmr_d = '0;
          fail_d     = '0;
          state_d    = S_IDLE;
        end else begin
          lock_tmr_d = lock_tmr_q - 16'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // op/code registers are cleared on every transfer, so they read 0 outside ISSUE.
  assign cmd_valid  = (state_q == S_ISSUE);
  assign cmd_op     = op_q;
  assign cmd_code   = code_q;
  assign busy       = (state_q != S_IDLE);
  assign fail_count = fail_q;
  assign state_out  = state_q;
`ifdef LOCK_LOCKOUT_EN
  assign locked_out = (state_q == S_LOCK);
`else
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_lock_cmd_issuer.sv
// Directed bench for lock_cmd_issuer with DEBOUNCE_CYCLES=4, MAX_FAILS=3, LOCKOUT_CYCLES=20, RESP_TIMEOUT=10.
module tb_lock_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_set_raw = 1'b0;
  logic       btn_enter_raw = 1'b0;
  logic [6:0] code_sw = '0;
  logic       cmd_ready = 1'b0;
  logic       resp_valid = 1'b0;
  logic       resp_ok = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [6:0] cmd_code;
  logic       busy;
  logic       locked_out;
  logic [2:0] fail_count;
  logic [1:0] state_out;

  int total = 0;
  int bad   = 0;

  lock_cmd_issuer #(
    .DEBOUNCE_CYCLES(16'd4),
    .MAX_FAILS      (3'd3),
    .LOCKOUT_CYCLES (16'd20),
    .RESP_TIMEOUT   (8'd10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_set_raw  (btn_set_raw),
    .btn_enter_raw(btn_enter_raw),
    .code_sw      (code_sw),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_code     (cmd_code),
    .cmd_ready    (cmd_ready),
    .resp_valid   (resp_valid),
    .resp_ok      (resp_ok),
    .busy         (busy),
    .locked_out   (locked_out),
    .fail_count   (fail_count),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press enter long enough to debounce, release, and let the CHECK issue and transfer.
  task automatic issue_check();
    cmd_ready     = 1'b1;
    btn_enter_raw = 1'b1;
    repeat (10) tick();
    btn_enter_raw = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    logic [16:0] outs;
    #2;
    outs = {cmd_valid, cmd_op, cmd_code, busy, locked_out, fail_count, state_out};
    total++;
    if (outs !== 17'h0) begin bad++; $display("FAIL reset_outputs: got %05h want 00000", outs); end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    total++;
    if (state_out !== 2'd0) begin bad++; $display("FAIL reset_release_state: got %0d want 0", state_out); end
  endtask

  task automatic test_debounce();
    logic exp_v;
    code_sw     = 7'h2A;
    cmd_ready   = 1'b1;
    btn_set_raw = 1'b1;
    repeat (10) tick();
    btn_set_raw = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_v = (i == 7);
      total++;
      if (cmd_valid !== exp_v) begin bad++; $display("FAIL debounce_valid_t%0d: got %b want %b", i, cmd_valid, exp_v); end
      if (i == 7) begin
        total++;
        if (cmd_op !== 2'b01) begin bad++; $display("FAIL debounce_op: got %b want 01", cmd_op); end
        total++;
        if (cmd_code !== 7'h2A) begin bad++; $display("FAIL debounce_code: got %h want 2a", cmd_code); end
      end
    end
    total++;
    if ({busy, state_out, cmd_op} !== 5'b0) begin bad++; $display("FAIL debounce_idle: got busy=%b state=%0d op=%b want 0", busy, state_out, cmd_op); end
  endtask

  task automatic test_glitch();
    logic seen;
    for (int w = 1; w <= 3; w++) begin
      btn_enter_raw = 1'b1;
      repeat (w) tick();
      btn_enter_raw = 1'b0;
      seen = 1'b0;
      repeat (12) begin
        tick();
        seen |= cmd_valid | (state_out != 2'd0);
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL glitch_w%0d: got activity=%b want 0", w, seen); end
    end
  endtask

  task automatic test_handshake();
    logic stable;
    logic seen;
    cmd_ready     = 1'b0;
    code_sw       = 7'h55;
    btn_enter_raw = 1'b1;
    btn_set_raw   = 1'b1;
    repeat (10) tick();
    btn_enter_raw = 1'b0;
    repeat (2) tick();
    btn_set_raw = 1'b0;
    repeat (5) tick();
    total++;
    if ({cmd_valid, cmd_op, cmd_code} !== {1'b1, 2'b10, 7'h55}) begin
      bad++; $display("FAIL hs_issue: got v=%b op=%b code=%h want 1 10 55", cmd_valid, cmd_op, cmd_code);
    end
    stable = 1'b1;
    repeat (4) begin
      tick();
      if ({cmd_valid, cmd_op, cmd_code, state_out} !== {1'b1, 2'b10, 7'h55, 2'd1}) stable = 1'b0;
    end
    total++;
    if (stable !== 1'b1) begin bad++; $display("FAIL hs_hold_stable: got %b want 1", stable); end
    cmd_ready = 1'b1;
    tick();
    total++;
    if ({state_out, cmd_valid} !== {2'd2, 1'b0}) begin bad++; $display("FAIL hs_transfer: got state=%0d v=%b want 2 0", state_out, cmd_valid); end
    resp_valid = 1'b1;
    resp_ok    = 1'b1;
    tick();
    resp_valid = 1'b0;
    total++;
    if ({state_out, fail_count} !== 5'b0) begin bad++; $display("FAIL hs_resp_ok: got state=%0d fails=%0d want 0 0", state_out, fail_count); end
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen |= cmd_valid;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL hs_set_dropped: got %b want 0", seen); end
  endtask

  task automatic test_verdicts();
    int   highs;
    logic seen;
    for (int n = 1; n <= 3; n++) begin
      issue_check();
      total++;
      if (state_out !== 2'd2) begin bad++; $display("FAIL verdict_wait_%0d: got %0d want 2", n, state_out); end
      resp_valid = 1'b1;
      resp_ok    = 1'b0;
      tick();
      resp_valid = 1'b0;
      if (n < 3) begin
        total++;
        if ({fail_count, state_out} !== {3'(n), 2'd0}) begin
          bad++; $display("FAIL verdict_fail_%0d: got fails=%0d state=%0d want %0d 0", n, fail_count, state_out, n);
        end
      end
    end
`ifdef LOCK_LOCKOUT_EN
    total++;
    if ({state_out, locked_out, fail_count} !== {2'd3, 1'b1, 3'd3}) begin
      bad++; $display("FAIL lockout_entry: got state=%0d lo=%b fails=%0d want 3 1 3", state_out, locked_out, fail_count);
    end
    highs = 1;
    seen  = 1'b0;
    btn_enter_raw = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      if (i == 6) btn_enter_raw = 1'b0;
      tick();
      if (locked_out) highs++;
      seen |= cmd_valid;
    end
    total++;
    if (highs !== 20) begin bad++; $display("FAIL lockout_length: got %0d want 20", highs); end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL lockout_btn_ignored: got %b want 0", seen); end
    total++;
    if ({fail_count, state_out} !== 5'b0) begin bad++; $display("FAIL lockout_exit: got fails=%0d state=%0d want 0 0", fail_count, state_out); end
`else
    highs = 0;
    seen  = 1'b0;
    total++;
    if ({state_out, locked_out, fail_count} !== {2'd0, 1'b0, 3'd3}) begin
      bad++; $display("FAIL nolock_third: got state=%0d lo=%b fails=%0d want 0 0 3", state_out, locked_out, fail_count);
    end
    issue_check();
    resp_valid = 1'b1;
    resp_ok    = 1'b0;
    tick();
    resp_valid = 1'b0;
    total++;
    if ({fail_count, state_out} !== {3'd4, 2'd0}) begin bad++; $display("FAIL nolock_fourth: got fails=%0d state=%0d want 4 0", fail_count, state_out); end
    issue_check();
    resp_valid = 1'b1;
    resp_ok    = 1'b1;
    tick();
    resp_valid = 1'b0;
    total++;
    if (fail_count !== 3'd0) begin bad++; $display("FAIL nolock_ok_clears: got %0d want 0", fail_count); end
`endif
  endtask

  task automatic test_timeout();
    logic waiting;
    issue_check();
    resp_ok = 1'b0;
    waiting = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if ({state_out, fail_count} !== {2'd2, 3'd0}) waiting = 1'b0;
    end
    total++;
    if (waiting !== 1'b1) begin bad++; $display("FAIL timeout_early: got %b want 1", waiting); end
    tick();
    total++;
    if ({fail_count, state_out} !== {3'd1, 2'd0}) begin bad++; $display("FAIL timeout_count: got fails=%0d state=%0d want 1 0", fail_count, state_out); end
    issue_check();
    repeat (9) tick();
    resp_valid = 1'b1;
    resp_ok    = 1'b1;
    tick();
    resp_valid = 1'b0;
    total++;
    if ({fail_count, state_out} !== 5'b0) begin bad++; $display("FAIL timeout_resp_wins: got fails=%0d state=%0d want 0 0", fail_count, state_out); end
  endtask

  task automatic test_reset_mid_issue();
    logic [16:0] outs;
    logic        seen;
    cmd_ready     = 1'b0;
    code_sw       = 7'h11;
    btn_enter_raw = 1'b1;
    repeat (10) tick();
    btn_enter_raw = 1'b0;
    repeat (7) tick();
    total++;
    if (cmd_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid: got %b want 1", cmd_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    outs = {cmd_valid, cmd_op, cmd_code, busy, locked_out, fail_count, state_out};
    total++;
    if (outs !== 17'h0) begin bad++; $display("FAIL rst_async_outputs: got %05h want 00000", outs); end
    tick();
    rst_n     = 1'b1;
    cmd_ready = 1'b1;
    seen      = 1'b0;
    repeat (12) begin
      tick();
      seen |= cmd_valid | busy;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rst_no_residual: got %b want 0", seen); end
    code_sw       = 7'h33;
    btn_set_raw   = 1'b1;
    btn_enter_raw = 1'b1;
    repeat (10) tick();
    btn_set_raw   = 1'b0;
    btn_enter_raw = 1'b0;
    repeat (7) tick();
    total++;
    if ({cmd_valid, cmd_op, cmd_code} !== {1'b1, 2'b10, 7'h33}) begin
      bad++; $display("FAIL both_check_wins: got v=%b op=%b code=%h want 1 10 33", cmd_valid, cmd_op, cmd_code);
    end
    tick();
    total++;
    if (state_out !== 2'd2) begin bad++; $display("FAIL both_wait: got %0d want 2", state_out); end
    resp_valid = 1'b1;
    resp_ok    = 1'b1;
    tick();
    resp_valid = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen |= cmd_valid;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL both_set_dropped: got %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_handshake();
    test_verdicts();
    test_timeout();
    test_reset_mid_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
